mdu_core: RTL and testbench
===========================

# mdu_core

Parametrised multiply/divide unit serving the execute stage of the pipelined MIPS core. It holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU plus the accumulate forms MADD/MADDU/MSUB/MSUBU. Each operation has a configurable fixed latency and a start/busy handshake. A cancel input lets the exception logic squash an in-flight operation without touching HI/LO.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (>=2)
- MULT_CYCLES, 5, busy cycles for multiply/accumulate ops (>=1)
- DIV_CYCLES, 10, busy cycles for divide ops (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  issue request, sampled every edge
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10-15 ignored (no effect)
- src_a  in  WIDTH  rs operand / dividend / MTHI-MTLO data
- src_b  in  WIDTH  rt operand / divisor
- cancel  in  1  squash (exception/interrupt flush)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse after a commit
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Reset: busy=0, done=0, hi=0, lo=0, latency counter=0, captured op/operands cleared. Reset mid-operation aborts it with no commit.
- Accept: start=1 && busy=0 && cancel=0 at an edge.
  - src_a, src_b and op are captured at that edge.
  - start while busy=1 is ignored. The core must stall mult/div/mfhi/mflo/mthi/mtlo while busy.
- MTHI/MTLO: write src_a into hi/lo at the accept edge. No busy, no done.
- MULT/MULTU: {hi,lo} = signed/unsigned src_a*src_b, full 2*WIDTH product.
- MADD/MADDU: {hi,lo} = {hi,lo} + product. MSUB/MSUBU: {hi,lo} = {hi,lo} - product.
  - Product sign-extended (signed forms) or zero-extended (unsigned forms) to 2*WIDTH.
  - Result taken modulo 2^(2*WIDTH); no overflow flag.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - -2^(WIDTH-1)/-1 gives lo=-2^(WIDTH-1), hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV and DIVU): lo = all ones, hi = src_a.
- Cancel=1 at any edge:
  - Drops the in-flight op: busy->0, no commit, no done.
  - Blocks any accept in that cycle, MTHI/MTLO included.
  - Cancel on the commit edge wins: no commit.
- Illegal op codes on start: no accept; busy stays 0.

## Timing
- Accept at edge E0 with latency L (MULT_CYCLES or DIV_CYCLES):
  - busy=1 from E0 through E_L, i.e. high exactly L cycles.
  - hi/lo updated at E_L; busy falls at E_L.
  - done=1 for the single cycle after E_L.
- New accept allowed at E_L+1 (the first edge with busy=0), i.e. back-to-back ops with L cycles each.
- hi/lo hold their old values for the whole busy window. The accumulate base is the hi/lo value at commit, which equals the value at accept.
- Latency counter width is clog2(max(MULT_CYCLES,DIV_CYCLES)+1). It loads L at accept, decrements while busy, and commits when it is 1.
- MTHI/MTLO results are visible on hi/lo the cycle after the accept edge.

## Test plan
(WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
- Reset, then MULT a=0xFFFFFFFE b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU 7/2 -> busy 10 cycles, lo=3, hi=1. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5. DIVU 0/0 -> lo=0xFFFFFFFF, hi=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Then MTHI 0, MTLO 0, MSUB 1*1 -> hi=lo=0xFFFFFFFF.
- MULT in flight; second start on busy cycle 2 -> ignored. cancel on busy cycle 3 -> busy=0 next cycle, hi/lo unchanged, no done. cancel coincident with MTLO start -> lo unchanged.
- DIV started, reset asserted on busy cycle 6 -> next cycle busy=0, hi=lo=0, done=0; no commit afterwards.

Source files
------------

// File: rtl/mdu_core.sv
// mdu_core: multiply/divide unit holding the architectural HI/LO registers.
// Operations are captured at accept and run for a fixed latency. The result
// is computed combinationally from the captured operands and the live HI/LO,
// and is written on the commit edge. A cancel squashes the in-flight
// operation without writing HI/LO.
module mdu_core #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXL = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    logic [CW-1:0]      cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;

    logic               mul_signed, div_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, res;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   ua, ub, ub_safe, qm, rm, quo, rem;

    // Datapath: product/accumulate and sign-magnitude division of the captured operands
    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        div_signed = (op_q == OP_DIV);

        // Extending both operands to 2*WIDTH makes a plain truncated multiply
        // give the correct two's-complement product for the signed forms.
        a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
        acc   = {hi, lo};

        // Divide on magnitudes; the most-negative dividend's magnitude is
        // exact as an unsigned value, so MIN/-1 wraps back to MIN.
        neg_a   = div_signed & a_q[WIDTH-1];
        neg_b   = div_signed & b_q[WIDTH-1];
        ua      = neg_a ? -a_q : a_q;
        ub      = neg_b ? -b_q : b_q;
        ub_safe = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
        qm      = ua / ub_safe;
        rm      = ua % ub_safe;
        quo     = (neg_a ^ neg_b) ? -qm : qm;
        rem     = neg_a ? -rm : rm;

        res = acc;
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            OP_DIV, OP_DIVU:   res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
            default:           res = acc;
        endcase
    end

    // Control and architectural state: accept, latency countdown, commit, cancel
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else if (busy) begin
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    done <= 1'b1;
                    hi   <= res[2*WIDTH-1:WIDTH];
                    lo   <= res[WIDTH-1:0];
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else if (start && (op <= OP_MTLO)) begin
                case (op)
                    OP_MTHI: hi <= src_a;
                    OP_MTLO: lo <= src_a;
                    default: begin
                        busy <= 1'b1;
                        cnt  <= ((op == OP_DIV) || (op == OP_DIVU)) ? CW'(DIV_CYCLES)
                                                                     : CW'(MULT_CYCLES);
                        op_q <= op;
                        a_q  <= src_a;
                        b_q  <= src_b;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: table-driven directed checks of mdu_core plus hand-written
// sequences for ignore-while-busy, cancel and reset-mid-operation.
module tb_mdu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mdu_core #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
        .src_b(src_b), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one request for one clock edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; cancel = c;
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l, input string nm);
        issue(4'd8, h, 32'h0, 1'b0);
        issue(4'd9, l, 32'h0, 1'b0);
        @(negedge clk);
        chk({nm, " preset hi/lo"}, {hi, lo}, {h, l});
        chk({nm, " preset busy"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] sh, sl;
        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'h3,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{4'd1, 32'hFFFFFFFE, 32'h3,        32'h0, 32'h0,        32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{4'd3, 32'h7,        32'h2,        32'h0, 32'h0,        32'h1,        32'h3};
        vecs[3]  = '{4'd2, 32'hFFFFFFF9, 32'h2,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h0,        32'h80000000};
        vecs[5]  = '{4'd2, 32'h5,        32'h0,        32'h0, 32'h0,        32'h5,        32'hFFFFFFFF};
        vecs[6]  = '{4'd3, 32'h0,        32'h0,        32'h7, 32'h7,        32'h0,        32'hFFFFFFFF};
        vecs[7]  = '{4'd5, 32'h1,        32'h1,        32'h0, 32'hFFFFFFFF, 32'h1,        32'h0};
        vecs[8]  = '{4'd6, 32'h1,        32'h1,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[9]  = '{4'd2, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,        32'h1,        32'hFFFFFFFD};
        vecs[10] = '{4'd4, 32'hFFFFFFFF, 32'h2,        32'h0, 32'h10,       32'h0,        32'hE};
        vecs[11] = '{4'd7, 32'h2,        32'h3,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[12] = '{4'd3, 32'hFFFFFFFF, 32'h10,       32'h0, 32'h0,        32'hF,        32'h0FFFFFFF};
        vecs[13] = '{4'd0, 32'h80000000, 32'h80000000, 32'h0, 32'h0,        32'h40000000, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy/done", {62'b0, busy, done}, 64'd0);
        chk("reset hi/lo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // Table: preset HI/LO, run the op, check latency, done pulse and result
        for (int i = 0; i < 14; i++) begin
            int lat;
            lat = (vecs[i].op == 4'd2 || vecs[i].op == 4'd3) ? 10 : 5;
            set_hilo(vecs[i].pre_hi, vecs[i].pre_lo, $sformatf("v%0d", i));
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            n = 0;
            @(negedge clk);
            while (busy && n < 50) begin
                chk($sformatf("v%0d hold hi/lo", i), {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
                n++;
                @(negedge clk);
            end
            chk($sformatf("v%0d busy cycles", i), 64'(n), 64'(lat));
            chk($sformatf("v%0d done", i), {63'b0, done}, 64'd1);
            chk($sformatf("v%0d hi/lo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            @(negedge clk);
            chk($sformatf("v%0d done drop", i), {63'b0, done}, 64'd0);
        end

        // Illegal op: no accept
        set_hilo(32'h11, 32'h22, "illegal");
        issue(4'd12, 32'h5, 32'h5, 1'b0);
        @(negedge clk);
        chk("illegal busy", {63'b0, busy}, 64'd0);
        chk("illegal hi/lo", {hi, lo}, {32'h11, 32'h22});

        // MULT in flight; start on busy cycle 2 ignored; cancel on busy cycle 3
        issue(4'd0, 32'h3, 32'h4, 1'b0);
        @(negedge clk);
        chk("mult c1 busy", {63'b0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b1; op = 4'd9; src_a = 32'hDEAD;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mult c3 busy", {63'b0, busy}, 64'd1);
        chk("ignored start lo", {32'b0, lo}, 64'h22);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel busy", {63'b0, busy}, 64'd0);
        chk("cancel hi/lo", {hi, lo}, {32'h11, 32'h22});
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy || hi != 32'h11 || lo != 32'h22) n++;
        end
        chk("cancel quiet after", 64'(n), 64'd0);

        // Cancel coincident with MTLO start
        issue(4'd9, 32'hDEAD, 32'h0, 1'b1);
        @(negedge clk);
        chk("cancel mtlo lo", {32'b0, lo}, 64'h22);

        // Cancel on the commit edge wins
        issue(4'd1, 32'h3, 32'h4, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("commit-cancel busy/done", {62'b0, busy, done}, 64'd0);
        chk("commit-cancel hi/lo", {hi, lo}, {32'h11, 32'h22});

        // Reset on DIV busy cycle 6
        issue(4'd2, 32'h64, 32'h7, 1'b0);
        repeat (5) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset-mid busy/done", {62'b0, busy, done}, 64'd0);
        chk("reset-mid hi/lo", {hi, lo}, 64'd0);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sh = hi; sl = lo;
            if (done || busy || sh != 0 || sl != 0) n++;
        end
        chk("reset-mid no commit", 64'(n), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
